// File: rtl/cascade_slave_responder.sv
// Cascade-slave INTA responder: on a matching cascade code, answers the INTA pulses with a vector or a CALL address.
// Optional gap timeout with seq_abort is enabled by defining CASRESP_TIMEOUT_EN.
module cascade_slave_responder (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inta_n,
  input  logic [2:0] cas_in,
  input  logic       slave_mode,
  input  logic [2:0] slave_id,
  input  logic       upm,
  input  logic       int_pending,
  input  logic [2:0] irq_level,
  input  logic [4:0] vector_base,
  input  logic [7:0] addr_lo,
  input  logic [7:0] addr_hi,
  output logic [7:0] data_out,
  output logic       data_oe,
  output logic       ack_start,
  output logic [2:0] ack_level,
  output logic       ack_done,
  output logic       seq_abort
);

  typedef enum logic [2:0] {IDLE, LOW1, GAP1, LOW2, GAP2, LOW3} state_t;

  state_t     state_q, state_d;
  logic       inta_q, live_q;
  logic       fall, rise;
  logic       upm_q, upm_d;
  logic [2:0] level_d;
  logic [7:0] dout_d;
  logic       oe_d, start_d, done_d;
  logic       in_gap, gap_timeout;

  // live_q masks the first cycle after reset so a level already low is not a fall
  assign fall   = live_q & inta_q & ~inta_n;
  assign rise   = ~inta_q & inta_n;
  assign in_gap = (state_q == GAP1) || (state_q == GAP2);

`ifdef CASRESP_TIMEOUT_EN
  logic [7:0] gap_cnt_q;

  // counter sits at 0 outside the gaps, so entering a gap starts it from zero
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gap_cnt_q <= 8'd0;
      seq_abort <= 1'b0;
    end else begin
      gap_cnt_q <= in_gap ? gap_cnt_q + 8'd1 : 8'd0;
      seq_abort <= in_gap & ~fall & gap_timeout;
    end
  end

  assign gap_timeout = (gap_cnt_q == 8'd254);
`else
  assign gap_timeout = 1'b0;
  assign seq_abort   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      inta_q    <= 1'b1;
      live_q    <= 1'b0;
      upm_q     <= 1'b0;
      ack_level <= 3'd0;
      data_out  <= 8'd0;
      data_oe   <= 1'b0;
      ack_start <= 1'b0;
      ack_done  <= 1'b0;
    end else begin
      state_q   <= state_d;
      inta_q    <= inta_n;
      live_q    <= 1'b1;
      upm_q     <= upm_d;
      ack_level <= level_d;
      data_out  <= dout_d;
      data_oe   <= oe_d;
      ack_start <= start_d;
      ack_done  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    upm_d   = upm_q;
    level_d = ack_level;
    dout_d  = data_out;
    oe_d    = data_oe;
    start_d = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (fall && slave_mode && (cas_in == slave_id) && int_pending) begin
          state_d = LOW1;
          upm_d   = upm;
          level_d = irq_level;
          start_d = 1'b1;
        end
      end
      LOW1: begin
        if (rise) begin
          state_d = GAP1;
          oe_d    = 1'b0;
          dout_d  = 8'd0;
        end
      end
      GAP1: begin
        if (fall) begin
          state_d = LOW2;
          oe_d    = 1'b1;
          dout_d  = upm_q ? {vector_base, ack_level} : addr_lo;
        end else if (gap_timeout) begin
          state_d = IDLE;
        end
      end
      LOW2: begin
        if (rise) begin
          oe_d   = 1'b0;
          dout_d = 8'd0;
          if (upm_q) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = GAP2;
          end
        end
      end
      GAP2: begin
        if (fall) begin
          state_d = LOW3;
          oe_d    = 1'b1;
          dout_d  = addr_hi;
        end else if (gap_timeout) begin
          state_d = IDLE;
        end
      end
      LOW3: begin
        if (rise) begin
          state_d = IDLE;
          oe_d    = 1'b0;
          dout_d  = 8'd0;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
